// File: rtl/alu_issue_decoder_if.sv
// -----------------------------------------------------------------------------
// alu_issue_if
//   Bundles the instruction handshake and the decoded-bundle handshake of the
//   ALU issue decoder into one interface.
//
//   Signals:
//     instr_i        [31:0]  RV32I instruction word
//     instr_valid_i          instr_i valid
//     instr_ready_o          decoder can accept an instruction (registered)
//     dec_valid_o            decoded bundle valid
//     dec_ready_i            ALU stage accepts the bundle
//     alu_op_o      [W-1:0]  ALU operation, W = `ALU_OP_WIDTH
//     b_imm_sel_o            1: ALU B operand is imm_o, 0: rs2
//     imm_o         [31:0]   sign-extended immediate
//     rs1_o/rs2_o/rd_o [4:0] register indices
//     reg_we_o               writeback enable
//     branch_o               conditional branch, ALU flag decides the outcome
//     illegal_o              instruction was not decodable
//
//   Modports: master = instruction producer / bundle consumer,
//             slave  = the decoder itself.
//
//   The ALU_* encodings normally come from define.v; the guarded defaults
//   below only apply when define.v is not on the file list.
// -----------------------------------------------------------------------------
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLTS 4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_EQ   4'd10
`define ALU_NE   4'd11
`define ALU_LTS  4'd12
`define ALU_GES  4'd13
`define ALU_LTU  4'd14
`define ALU_GEU  4'd15
`endif

interface alu_issue_if;
    logic [31:0]              instr_i;
    logic                     instr_valid_i;
    logic                     instr_ready_o;
    logic                     dec_valid_o;
    logic                     dec_ready_i;
    logic [`ALU_OP_WIDTH-1:0] alu_op_o;
    logic                     b_imm_sel_o;
    logic [31:0]              imm_o;
    logic [4:0]               rs1_o;
    logic [4:0]               rs2_o;
    logic [4:0]               rd_o;
    logic                     reg_we_o;
    logic                     branch_o;
    logic                     illegal_o;

    modport master (
        output instr_i, instr_valid_i, dec_ready_i,
        input  instr_ready_o, dec_valid_o, alu_op_o, b_imm_sel_o, imm_o,
               rs1_o, rs2_o, rd_o, reg_we_o, branch_o, illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i, dec_ready_i,
        output instr_ready_o, dec_valid_o, alu_op_o, b_imm_sel_o, imm_o,
               rs1_o, rs2_o, rd_o, reg_we_o, branch_o, illegal_o
    );
endinterface

// File: rtl/alu_issue_decoder.sv
// -----------------------------------------------------------------------------
// alu_issue_decoder
//   Decodes RV32I ALU-class instructions (OP, OP-IMM, BRANCH, LOAD, STORE,
//   LUI) into an ALU issue bundle and queues the bundles in a 2-entry skid
//   FIFO. Decode is combinational on the incoming word; the FIFO entry stores
//   the already-decoded bundle, so the outputs come straight from a flop.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   alu_issue_if.slave (instruction in, decoded bundle out)
//
//   Configuration macro ALU_ISSUE_ILLEGAL_TRAP_EN:
//     defined   - illegal words are queued with illegal_o=1, reg_we=0,
//                 branch=0, alu_op=ALU_ADD.
//     undefined - illegal_o is constant 0 and illegal words are queued as a
//                 NOP bundle (ALU_ADD, reg_we=0, branch=0, imm=0).
// -----------------------------------------------------------------------------
module alu_issue_decoder (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic [`ALU_OP_WIDTH-1:0] alu_op;
        logic                     b_imm_sel;
        logic [31:0]              imm;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic                     reg_we;
        logic                     branch;
        logic                     illegal;
    } bundle_t;

    // OP and OP-IMM share one funct3 table; alt picks SUB/SRA over ADD/SRL.
    function automatic logic [`ALU_OP_WIDTH-1:0] arith_op(input logic [2:0] f3,
                                                          input logic       alt);
        case (f3)
            3'b000:  arith_op = alt ? `ALU_SUB : `ALU_ADD;
            3'b001:  arith_op = `ALU_SLL;
            3'b010:  arith_op = `ALU_SLTS;
            3'b011:  arith_op = `ALU_SLTU;
            3'b100:  arith_op = `ALU_XOR;
            3'b101:  arith_op = alt ? `ALU_SRA : `ALU_SRL;
            3'b110:  arith_op = `ALU_OR;
            default: arith_op = `ALU_AND;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7_zero;
    logic        f7_alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;

    assign instr   = bus.instr_i;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {instr[31:12], 12'b0};

    bundle_t dec;
    logic    dec_illegal;

    always_comb begin
        // NOTE: every signal written here gets a default before the case, so no
        // path leaves it unassigned and no latch is inferred.
        dec         = '0;
        dec.alu_op  = `ALU_ADD;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec_illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec.alu_op  = arith_op(funct3, f7_alt);
                dec.reg_we  = 1'b1;
                // Only SUB and SRA have an alternate funct7.
                dec_illegal = !(f7_zero ||
                                (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                // funct7 is immediate data except for the shift forms.
                dec.alu_op    = arith_op(funct3, f7_alt && (funct3 == 3'b101));
                dec.b_imm_sel = 1'b1;
                dec.imm       = imm_i;
                dec.reg_we    = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_illegal = !f7_zero;
                end else if (funct3 == 3'b101) begin
                    dec_illegal = !(f7_zero || f7_alt);
                end
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                case (funct3)
                    3'b000:  dec.alu_op = `ALU_EQ;
                    3'b001:  dec.alu_op = `ALU_NE;
                    3'b100:  dec.alu_op = `ALU_LTS;
                    3'b101:  dec.alu_op = `ALU_GES;
                    3'b110:  dec.alu_op = `ALU_LTU;
                    3'b111:  dec.alu_op = `ALU_GEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.b_imm_sel = 1'b1;
                dec.imm       = imm_i;
                dec.reg_we    = 1'b1;
            end
            OPC_STORE: begin
                dec.b_imm_sel = 1'b1;
                dec.imm       = imm_s;
            end
            OPC_LUI: begin
                dec.rs1       = 5'd0;
                dec.b_imm_sel = 1'b1;
                dec.imm       = imm_u;
                dec.reg_we    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // An undecodable word becomes a harmless ADD bundle; in the trap build
        // it additionally carries the illegal flag down the pipe.
        if (dec_illegal) begin
            dec        = '0;
            dec.alu_op = `ALU_ADD;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid FIFO of decoded bundles
    // ------------------------------------------------------------------
    bundle_t    mem_q [2];
    bundle_t    mem_d [2];
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       ready_q, ready_d;
    logic       push;
    logic       pop;

    // ready_q is exactly (count_q < 2), so a push can never hit a full FIFO.
    assign push = bus.instr_valid_i && ready_q;
    assign pop  = (count_q != 2'd0) && bus.dec_ready_i;

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            mem_d[wr_ptr_q] = dec;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Registered ready: computed from the next count, so instr_ready_o has
        // no combinational path from dec_ready_i.
        ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: the storage array has no reset; count_q=0 marks it empty and the
    // output gating below hides whatever it holds.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs: head entry, forced to zero while nothing is valid
    // ------------------------------------------------------------------
    bundle_t head;
    bundle_t out;

    assign head = mem_q[rd_ptr_q];
    assign out  = (count_q != 2'd0) ? head : '0;

    assign bus.instr_ready_o = ready_q;
    assign bus.dec_valid_o   = (count_q != 2'd0);
    assign bus.alu_op_o      = out.alu_op;
    assign bus.b_imm_sel_o   = out.b_imm_sel;
    assign bus.imm_o         = out.imm;
    assign bus.rs1_o         = out.rs1;
    assign bus.rs2_o         = out.rs2;
    assign bus.rd_o          = out.rd;
    assign bus.reg_we_o      = out.reg_we;
    assign bus.branch_o      = out.branch;
    // Without the trap macro the illegal field is never set, so this is a
    // constant 0.
    assign bus.illegal_o     = out.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_decoder
//   Self-checking bench for alu_issue_decoder: directed scenarios followed by
//   randomized traffic, all compared against a queue-based reference model
//   that decodes from the RV32I field rules.
// -----------------------------------------------------------------------------
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLTS 4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_EQ   4'd10
`define ALU_NE   4'd11
`define ALU_LTS  4'd12
`define ALU_GES  4'd13
`define ALU_LTU  4'd14
`define ALU_GEU  4'd15
`endif

module tb_alu_issue_decoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [`ALU_OP_WIDTH-1:0] alu_op;
        logic                     b_imm_sel;
        logic [31:0]              imm;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic                     reg_we;
        logic                     branch;
        logic                     illegal;
        logic                     bad;      // word was not decodable
    } exp_t;

    exp_t exp_q [$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    endtask

    // Reference decode built from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t                     e;
        logic [6:0]               opc;
        logic [2:0]               f3;
        logic [6:0]               f7;
        logic                     ok;
        logic [`ALU_OP_WIDTH-1:0] base [8];
        logic [`ALU_OP_WIDTH-1:0] bops [8];
        base = '{`ALU_ADD, `ALU_SLL, `ALU_SLTS, `ALU_SLTU,
                 `ALU_XOR, `ALU_SRL, `ALU_OR,   `ALU_AND};
        bops = '{`ALU_EQ, `ALU_NE, `ALU_ADD, `ALU_ADD,
                 `ALU_LTS, `ALU_GES, `ALU_LTU, `ALU_GEU};
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        e     = '0;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        ok    = 1'b1;
        case (opc)
            7'b0110011: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.alu_op = base[f3];
                if (f7 == 7'h20) e.alu_op = (f3 == 3'd0) ? `ALU_SUB : `ALU_SRA;
                e.reg_we = 1'b1;
            end
            7'b0010011: begin
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                e.alu_op    = (f3 == 3'd5 && f7 == 7'h20) ? `ALU_SRA : base[f3];
                e.b_imm_sel = 1'b1;
                e.imm       = $signed(w) >>> 20;
                e.reg_we    = 1'b1;
            end
            7'b1100011: begin
                ok       = (f3 != 3'd2) && (f3 != 3'd3);
                e.alu_op = bops[f3];
                e.branch = 1'b1;
                e.imm    = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            end
            7'b0000011: begin
                e.b_imm_sel = 1'b1;
                e.imm       = $signed(w) >>> 20;
                e.reg_we    = 1'b1;
            end
            7'b0100011: begin
                e.b_imm_sel = 1'b1;
                e.imm       = 32'($signed({w[31:25], w[11:7]}));
            end
            7'b0110111: begin
                e.rs1       = 5'd0;
                e.b_imm_sel = 1'b1;
                e.imm       = {w[31:12], 12'h000};
                e.reg_we    = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e        = '0;
            e.alu_op = `ALU_ADD;
            e.bad    = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            e.illegal = 1'b1;
`endif
        end
        return e;
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0, 1:    return 7'h00;
            2:       return 7'h20;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1: begin w[6:0] = 7'b0110011; w[31:25] = pick_f7(); end
            2, 3: begin w[6:0] = 7'b0010011; w[31:25] = pick_f7(); end
            4, 5: w[6:0] = 7'b1100011;
            6:    w[6:0] = 7'b0000011;
            7:    w[6:0] = 7'b0100011;
            8:    w[6:0] = 7'b0110111;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_outputs();
        exp_t e;
        check("instr_ready", 32'(bus.instr_ready_o), 32'(exp_q.size() < 2));
        check("dec_valid", 32'(bus.dec_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() == 0) begin
            check("idle_fields", 32'({bus.alu_op_o, bus.b_imm_sel_o, bus.rs1_o, bus.rs2_o,
                                      bus.rd_o, bus.reg_we_o, bus.branch_o, bus.illegal_o}), 32'd0);
            check("idle_imm", bus.imm_o, 32'd0);
        end else begin
            e = exp_q[0];
            check("alu_op", 32'(bus.alu_op_o), 32'(e.alu_op));
            check("reg_we", 32'(bus.reg_we_o), 32'(e.reg_we));
            check("branch", 32'(bus.branch_o), 32'(e.branch));
            check("illegal", 32'(bus.illegal_o), 32'(e.illegal));
            if (!e.bad || !e.illegal) check("imm", bus.imm_o, e.imm);
            if (!e.bad) begin
                check("b_imm_sel", 32'(bus.b_imm_sel_o), 32'(e.b_imm_sel));
                check("rs1", 32'(bus.rs1_o), 32'(e.rs1));
                check("rs2", 32'(bus.rs2_o), 32'(e.rs2));
                check("rd", 32'(bus.rd_o), 32'(e.rd));
            end
        end
    endtask

    // One clock: drive inputs, check the current outputs, clock, update model.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic r);
        logic do_push;
        logic do_pop;
        exp_t e;
        bus.instr_valid_i = v;
        bus.instr_i       = ins;
        bus.dec_ready_i   = rdy;
        rst               = r;
        check_outputs();
        do_push = v && (exp_q.size() < 2);
        do_pop  = (exp_q.size() != 0) && rdy;
        e       = ref_decode(ins);
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = 32'd0;
        bus.dec_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("rst_dec_valid", 32'(bus.dec_valid_o), 32'd0);
        check("rst_instr_ready", 32'(bus.instr_ready_o), 32'd1);

        // add x2,x1,x2
        step(1'b1, 32'h00208133, 1'b1, 1'b0);
        check("add_valid", 32'(bus.dec_valid_o), 32'd1);
        check("add_op", 32'(bus.alu_op_o), 32'(`ALU_ADD));
        check("add_rs1", 32'(bus.rs1_o), 32'd1);
        check("add_rs2", 32'(bus.rs2_o), 32'd2);
        check("add_rd", 32'(bus.rd_o), 32'd2);
        check("add_we", 32'(bus.reg_we_o), 32'd1);
        check("add_bsel", 32'(bus.b_imm_sel_o), 32'd0);
        drain();

        // Back-pressure: third push refused, head frozen, then in-order release
        step(1'b1, 32'h00308233, 1'b0, 1'b0);
        step(1'b1, 32'h40418333, 1'b0, 1'b0);
        check("full_ready", 32'(bus.instr_ready_o), 32'd0);
        check("full_head_rd", 32'(bus.rd_o), 32'd4);
        step(1'b1, 32'h0062F3B3, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("frozen_head_rd", 32'(bus.rd_o), 32'd4);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("second_rd", 32'(bus.rd_o), 32'd6);
        check("second_op", 32'(bus.alu_op_o), 32'(`ALU_SUB));
        drain();

        // Immediates
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        check("addi_imm", bus.imm_o, 32'hFFFFFFFF);
        check("addi_bsel", 32'(bus.b_imm_sel_o), 32'd1);
        step(1'b1, 32'h4030D093, 1'b1, 1'b0);
        check("srai_op", 32'(bus.alu_op_o), 32'(`ALU_SRA));
        check("srai_shamt", 32'(bus.imm_o[4:0]), 32'd3);

        // Branch
        step(1'b1, 32'h00209463, 1'b1, 1'b0);
        check("bne_op", 32'(bus.alu_op_o), 32'(`ALU_NE));
        check("bne_branch", 32'(bus.branch_o), 32'd1);
        check("bne_we", 32'(bus.reg_we_o), 32'd0);
        check("bne_imm", bus.imm_o, 32'd8);

        // Illegal word
        step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("ill_valid", 32'(bus.dec_valid_o), 32'd1);
        check("ill_we", 32'(bus.reg_we_o), 32'd0);
        check("ill_branch", 32'(bus.branch_o), 32'd0);
        check("ill_op", 32'(bus.alu_op_o), 32'(`ALU_ADD));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        check("ill_flag", 32'(bus.illegal_o), 32'd1);
`else
        check("ill_flag", 32'(bus.illegal_o), 32'd0);
        check("ill_imm", bus.imm_o, 32'd0);
`endif
        drain();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0);
        end
        drain();

        // Full FIFO, continuous ready and pushes, then reset mid-stream
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        check("fill_ready", 32'(bus.instr_ready_o), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b1, rand_instr(), 1'b1, 1'b0);
        step(1'b1, rand_instr(), 1'b1, 1'b1);
        check("midrst_valid", 32'(bus.dec_valid_o), 32'd0);
        check("midrst_ready", 32'(bus.instr_ready_o), 32'd1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
